// File: rtl/uart_tx_drain.sv
// UART transmitter that drains a first-word-fall-through FIFO, sending frames
// back-to-back (start, LSB-first data, stop) until the FIFO runs empty.
module uart_tx_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 868,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_c, done_c;
  logic                  baud_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // The stop period reuses the bit counter to count stop bits, so the final
  // stop cycle is the only place a back-to-back pop can happen mid-stream.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rd_c    = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          rd_c    = 1'b1;
          shift_d = r_data;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            done_c = 1'b1;
            bit_d  = '0;
            if (!empty) begin
              rd_c    = 1'b1;
              shift_d = r_data;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end else begin
      tx_d = 1'b1;
    end
  end

  assign rd           = rd_c & reset;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_c;

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmit stage that sits directly downstream of the synchronous FIFO. Whenever the FIFO is non-empty, it pops one word and shifts it out on a UART line: one start bit, DATA_WIDTH data bits LSB first, then STOP_BITS stop bits. There is no parity bit. It keeps popping and sending frames back-to-back until the FIFO runs empty, so the FIFO absorbs the producer's bursts while this block meters them out at line rate.

## Interface
Parameters:
- DATA_WIDTH, 8, frame data bits; must match the FIFO word width.
- BAUD_DIV, 868, clock cycles per serial bit; must be ≥ 2 (868 gives 115200 baud at 100 MHz).
- STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- empty  in  1  FIFO empty flag.
- r_data  in  DATA_WIDTH  FIFO head word; valid whenever empty=0 (first-word fall-through).
- rd  out  1  FIFO pop strobe; combinational, at most one cycle per frame.
- tx  out  1  serial line, registered; idles high.
- tx_busy  out  1  high while a frame is on the line.
- tx_done_tick  out  1  one-cycle pulse in the last cycle of each frame's stop period.

## Operation
- States: IDLE, START, DATA, STOP.
- Counters:
  - Baud counter, width $clog2(BAUD_DIV), counts 0..BAUD_DIV-1.
  - Bit counter, width $clog2(DATA_WIDTH)+1, counts data bits and stop bits.
  - Shift register, DATA_WIDTH bits.
- IDLE:
  - tx=1, tx_busy=0.
  - If empty=0: rd=1 in the same cycle. At the clock edge, load shift register from r_data, clear counters, go to START.
- START: tx=0 for BAUD_DIV cycles, then go to DATA with bit counter 0.
- DATA:
  - tx = shift register bit 0. Each bit is held BAUD_DIV cycles.
  - At the end of each bit, shift right and increment the bit counter.
  - After DATA_WIDTH bits, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*BAUD_DIV cycles.
  - In the final cycle: tx_done_tick=1.
  - If empty=0 in that final cycle, rd=1, load r_data, go directly to START (back-to-back frame, no idle bit). Otherwise go to IDLE.
- rd is asserted only in those two situations:
  - IDLE with empty=0.
  - STOP final cycle with empty=0.
- rd is never asserted when empty=1. The FIFO itself also ignores underflow.
- tx_busy=1 in START, DATA and STOP, including the last STOP cycle even when the block then returns to IDLE.

## Timing
- Reset values (asynchronous, immediate on reset=0):
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, all counters 0, shift register 0.
  - rd=0 while reset is asserted.
- Pop-to-line latency: rd is high in cycle N, and tx falls to 0 in cycle N+1 because tx is registered from the next state.
- Frame length: (1 + DATA_WIDTH + STOP_BITS) * BAUD_DIV cycles, measured from the tx falling edge to the next possible start-bit edge.
- Sustained throughput with a non-empty FIFO: exactly one rd pulse per frame period, and no idle cycles between frames.
- If empty deasserts mid-frame, it has no effect until the STOP final cycle or IDLE.
- Reset mid-frame:
  - tx returns to 1 immediately and the block goes to IDLE.
  - The word already popped is discarded and is not re-sent.
  - After reset is released, the first frame starts cleanly with a full-length start bit.
- The FIFO pointers and the block share clk, so pop and write in the same cycle are legal and resolved by the FIFO.

## Test plan
- Single word, BAUD_DIV=4, STOP_BITS=1, FIFO holds 0xA5:
  - rd pulses once.
  - tx sequence, 4 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then 1.
  - tx_done_tick pulses in cycle 40 after rd.
  - The block returns to IDLE with tx=1.
- Back-to-back, FIFO holds 0x00 then 0xFF:
  - Two rd pulses exactly 40 cycles apart.
  - The stop bit of frame 1 is followed immediately by the start bit of frame 2.
  - tx_busy stays high for all 80 cycles.
- Empty FIFO for 200 cycles: rd never asserted, tx=1, tx_busy=0, tx_done_tick=0 throughout.
- STOP_BITS=2, BAUD_DIV=4, word 0x3C: stop period is 8 cycles high, frame length is 44 cycles, tx_done_tick is in the last of those cycles.
- Reset pulled low during data bit 3 of 0x81:
  - tx=1 in the same cycle, without waiting for a clock edge.
  - After release, with 0x55 in the FIFO, a complete correct frame for 0x55 is sent and no 0x81 remainder appears.
- FIFO refilled during the STOP final cycle (write lands while empty=1): no pop that cycle, the block enters IDLE, then pops the next cycle. This gives exactly one idle cycle between frames.
